// File: rtl/adc_spi_master.sv
// rtl/adc_spi_master.sv - multi-channel SPI ADC reader; optional feature macro ADC_LEADING_ZERO_CHECK_EN adds frame_err
module adc_spi_master #(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int CLK_DIV    = 4,
    parameter int QUIET_CYC  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          cont,
    input  logic [NUM_CH-1:0]             SDATA,
    output logic                          CS,
    output logic                          SCLK,
    output logic                          busy,
    output logic                          rx_done_tick,
    output logic [NUM_CH*DATA_BITS-1:0]   data_Out
`ifdef ADC_LEADING_ZERO_CHECK_EN
    ,
    output logic [NUM_CH-1:0]             frame_err
`endif
);

    // One shared counter times both the SCLK half-periods and the quiet gap.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam int CW    = (DIV_W > QW) ? DIV_W : QW;
    localparam int BW    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [BW-1:0]                        bit_q, bit_d;
    logic                                 ph_q, ph_d;     // 0: SCLK low phase, 1: high phase
    logic                                 sample;         // last cycle of a low phase
    logic                                 frame_end;      // last cycle of the final high phase
    logic [NUM_CH-1:0][FRAME_BITS-1:0]    sr_q;
    logic [NUM_CH*DATA_BITS-1:0]          data_q;
    logic                                 tick_q;
    logic                                 cs_q;
    logic                                 sclk_q;

    // State, counters and phase register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
        end
    end

    // Next-state logic: LEAD, then FRAME_BITS low/high periods, then the quiet gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        ph_d      = ph_q;
        sample    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || cont) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                end
            end
            ST_LEAD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ph_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!ph_q) begin
                        ph_d   = 1'b1;
                        sample = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d   = ST_QUIET;
                        ph_d      = 1'b0;
                        bit_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        ph_d  = 1'b0;
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d   = '0;
                    state_d = cont ? ST_LEAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CS/SCLK registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cs_q   <= !((state_d == ST_LEAD) || (state_d == ST_SHIFT));
            sclk_q <= !((state_d == ST_SHIFT) && !ph_d);
            tick_q <= frame_end;
        end
    end

    // Per-channel shift registers and result capture at frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sample) begin
                    sr_q[i] <= (sr_q[i] << 1) | FRAME_BITS'(SDATA[i]);
                end
                if (frame_end) begin
                    data_q[i*DATA_BITS +: DATA_BITS] <= sr_q[i][DATA_BITS-1:0];
                end
            end
        end
    end

`ifdef ADC_LEADING_ZERO_CHECK_EN
    logic [NUM_CH-1:0] err_q;

    // Flag any set bit above the result field, captured alongside data_Out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < NUM_CH; i++) begin
                err_q[i] <= |(sr_q[i] >> DATA_BITS);
            end
        end
    end

    assign frame_err = err_q;
`else
    // Upper frame bits only feed the leading-zero check.
    logic unused_sr_hi;
    assign unused_sr_hi = ^sr_q;
`endif

    assign CS           = cs_q;
    assign SCLK         = sclk_q;
    assign busy         = (state_q != ST_IDLE);
    assign rx_done_tick = tick_q;
    assign data_Out     = data_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// tb/tb_adc_spi_master.sv - self-checking bench for adc_spi_master
`timescale 1ns/1ps
module tb_adc_spi_master;

    localparam int NCH = 2;
    localparam int FB  = 16;
    localparam int DB  = 12;
    localparam int DIV = 2;
    localparam int QC  = 4;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, cont, start2, cont2;
    logic [NCH-1:0]    sdata;
    logic              cs, sclk, busy, tick;
    logic [NCH*DB-1:0] dout;
    logic [0:0]        sdata2;
    logic              cs2, sclk2, busy2, tick2;
    logic [DB-1:0]     dout2;
`ifdef ADC_LEADING_ZERO_CHECK_EN
    logic [NCH-1:0]    ferr;
    logic [0:0]        ferr2;
`endif

    adc_spi_master #(.NUM_CH(NCH), .FRAME_BITS(FB), .DATA_BITS(DB), .CLK_DIV(DIV), .QUIET_CYC(QC)) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .SDATA(sdata),
        .CS(cs), .SCLK(sclk), .busy(busy), .rx_done_tick(tick), .data_Out(dout)
`ifdef ADC_LEADING_ZERO_CHECK_EN
        , .frame_err(ferr)
`endif
    );

    adc_spi_master #(.NUM_CH(1), .FRAME_BITS(FB), .DATA_BITS(DB), .CLK_DIV(1), .QUIET_CYC(QC)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cont(cont2), .SDATA(sdata2),
        .CS(cs2), .SCLK(sclk2), .busy(busy2), .rx_done_tick(tick2), .data_Out(dout2)
`ifdef ADC_LEADING_ZERO_CHECK_EN
        , .frame_err(ferr2)
`endif
    );

    int tests = 0;
    int fails = 0;

    // ADC models: each presents its frame MSB first, next bit after every SCLK rise.
    logic [FB-1:0] frame [NCH];
    logic [FB-1:0] frame2;
    int bit_idx  = 0;
    int bit_idx2 = 0;

    always @(posedge sclk or posedge cs) begin
        if (cs) bit_idx = 0;
        else    bit_idx++;
    end

    always @(posedge sclk2 or posedge cs2) begin
        if (cs2) bit_idx2 = 0;
        else     bit_idx2++;
    end

    always_comb begin
        sdata = '0;
        for (int i = 0; i < NCH; i++) begin
            sdata[i] = (bit_idx < FB) ? frame[i][FB-1-bit_idx] : 1'b0;
        end
    end

    always_comb begin
        sdata2 = '0;
        sdata2[0] = (bit_idx2 < FB) ? frame2[FB-1-bit_idx2] : 1'b0;
    end

    // Bus monitors: CS low length, CS high gap, tick count, SCLK toggles.
    int tick_cnt = 0;
    int low_run = 0, high_run = 0, last_low = 0, last_gap = 0;
    logic prev_cs = 1'b1;
    int low2 = 0, tog2 = 0, last_low2 = 0, last_tog2 = 0;
    logic prev_cs2 = 1'b1, prev_sclk2 = 1'b1;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt++;
        if (cs === 1'b0) begin
            if (prev_cs) begin
                last_gap = high_run;
                low_run  = 0;
            end
            low_run++;
        end else begin
            if (!prev_cs) begin
                last_low = low_run;
                high_run = 0;
            end
            high_run++;
        end
        prev_cs = cs;

        if (cs2 === 1'b0) begin
            if (prev_cs2) begin
                low2 = 0;
                tog2 = 0;
            end
            low2++;
            if (sclk2 !== prev_sclk2) tog2++;
        end else if (!prev_cs2) begin
            last_low2 = low2;
            last_tog2 = tog2;
        end
        prev_cs2   = cs2;
        prev_sclk2 = sclk2;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result word: each channel keeps its frame modulo 2^DB.
    function automatic logic [63:0] exp_data();
        logic [63:0] r = 64'd0;
        for (int i = 0; i < NCH; i++) begin
            r = r + ((64'(frame[i]) % (64'd1 << DB)) << (i * DB));
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_err();
        logic [63:0] r = 64'd0;
        for (int i = 0; i < NCH; i++) begin
            if ((frame[i] >> DB) != 0) r = r + (64'd1 << i);
        end
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        @(negedge clk);
        while (tick !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic randomize_frames();
        for (int i = 0; i < NCH; i++) frame[i] = 16'($urandom);
    endtask

    int t0;
    int n;

    initial begin
        reset = 1'b0; start = 1'b0; cont = 1'b0; start2 = 1'b0; cont2 = 1'b0;
        frame[0] = '0; frame[1] = '0; frame2 = '0;
        repeat (3) @(negedge clk);

        check("rst_cs",   64'(cs), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_data", 64'(dout), 64'd0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", 64'(busy), 64'd0);

        // Directed frame, with a start pulse during SHIFT that must be ignored.
        frame[0] = 16'h0ABC;
        frame[1] = 16'h0123;
        t0 = tick_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        pulse_start();
        wait_tick("dir");
        check("dir_data", 64'(dout), 64'h123ABC);
        wait_idle(n);
        check("busy_fall_after_tick", 64'(n), 64'(QC));
        check("cs_low_len", 64'(last_low), 64'(DIV + 2 * DIV * FB));
        repeat (100) @(negedge clk);
        check("one_tick_only", 64'(tick_cnt - t0), 64'd1);
        check("idle_cs_after", 64'(cs), 64'd1);

        // Random single-shot frames.
        for (int k = 0; k < 4; k++) begin
            randomize_frames();
            pulse_start();
            wait_tick("rnd");
            check("rnd_data", 64'(dout), exp_data());
`ifdef ADC_LEADING_ZERO_CHECK_EN
            check("rnd_err", 64'(ferr), exp_err());
`endif
            wait_idle(n);
            check("rnd_cs_low", 64'(last_low), 64'(DIV + 2 * DIV * FB));
        end

        // Continuous mode, then cont cleared mid-frame.
        randomize_frames();
        t0 = tick_cnt;
        cont = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_tick("cont");
            check("cont_data", 64'(dout), exp_data());
            if (k > 0) check("cont_gap", 64'(last_gap), 64'(QC));
            randomize_frames();
        end
        repeat (QC + DIV + 10) @(negedge clk);
        check("cont_in_frame", 64'(cs), 64'd0);
        cont = 1'b0;
        wait_tick("cont_last");
        check("cont_last_data", 64'(dout), exp_data());
        wait_idle(n);
        repeat (60) @(negedge clk);
        check("cont_tick_count", 64'(tick_cnt - t0), 64'd5);
        check("cont_stopped_cs", 64'(cs), 64'd1);
        check("cont_stopped_busy", 64'(busy), 64'd0);

        // Reset in the middle of a frame.
        randomize_frames();
        pulse_start();
        n = 0;
        while (bit_idx != 7 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("bit7_timeout", 64'd0, 64'd1);
        t0 = tick_cnt;
        reset = 1'b0;
        #1;
        check("mid_rst_cs",   64'(cs), 64'd1);
        check("mid_rst_sclk", 64'(sclk), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", 64'(dout), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        check("mid_rst_no_tick", 64'(tick_cnt - t0), 64'd0);
        check("mid_rst_idle", 64'(busy), 64'd0);
        randomize_frames();
        pulse_start();
        wait_tick("post_rst");
        check("post_rst_data", 64'(dout), exp_data());
        wait_idle(n);

`ifdef ADC_LEADING_ZERO_CHECK_EN
        // Leading-zero check.
        frame[0] = 16'h8ABC;
        frame[1] = 16'h0123;
        pulse_start();
        wait_tick("lz1");
        check("lz_err_set", 64'(ferr[0]), 64'd1);
        check("lz_data_set", 64'(dout[DB-1:0]), 64'hABC);
        wait_idle(n);
        frame[0] = 16'h0ABC;
        pulse_start();
        wait_tick("lz0");
        check("lz_err_clr", 64'(ferr[0]), 64'd0);
        wait_idle(n);
`endif

        // CLK_DIV=1 instance: all-ones frame, SCLK toggles every cycle.
        frame2 = 16'hFFFF;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (tick2 !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("div1_timeout", 64'd0, 64'd1);
        check("div1_data", 64'(dout2), 64'hFFF);
`ifdef ADC_LEADING_ZERO_CHECK_EN
        check("div1_err", 64'(ferr2), 64'd1);
`endif
        repeat (3) @(negedge clk);
        check("div1_cs_low", 64'(last_low2), 64'(1 + 2 * FB));
        check("div1_toggles", 64'(last_tog2), 64'(2 * FB));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
